// File: rtl/data_capture_fifo.sv
// Sampled capture of an asynchronous input bus into a FIFO read by a processor.
// Define DATA_CAPTURE_TEST_PATTERN_EN to add test_mode and a counting data source.
module data_capture_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 16
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic [DATA_W-1:0]      input_data_export,
    input  logic                   start,
    input  logic                   stop,
    input  logic [DIV_W-1:0]       divider,
    input  logic [15:0]            capture_len,
`ifdef DATA_CAPTURE_TEST_PATTERN_EN
    input  logic                   test_mode,
`endif
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   running,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] sync1_q, sync1_d;
    logic [DATA_W-1:0] sync2_q, sync2_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  dcnt_q, dcnt_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       scnt_q, scnt_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              go;
    logic              strobe;
    logic              full;
    logic              pop;
    logic              push;
    logic              last;
    logic [DATA_W-1:0] wdata;

`ifdef DATA_CAPTURE_TEST_PATTERN_EN
    logic [DATA_W-1:0] pat_q, pat_d;
`endif

    // stop wins over start; a stopping cycle takes no sample
    always_comb begin
        go     = start && !stop;
        strobe = (state_q == RUN) && !stop && (dcnt_q == '0);
        full   = (level_q == FULL_LVL);
        pop    = rd_en && (level_q != '0);
        push   = strobe && (!full || pop);
        last   = strobe && (len_q != 16'd0)
                 && ((scnt_q + 16'd1) == len_q);
    end

    always_comb begin
`ifdef DATA_CAPTURE_TEST_PATTERN_EN
        wdata = test_mode ? pat_q : sync2_q;
`else
        wdata = sync2_q;
`endif
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop || (last && !start)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        running = (state_q == RUN);
    end

    always_comb begin
        sync1_d = input_data_export;
        sync2_d = sync1_q;
        div_d   = div_q;
        len_d   = len_q;
        dcnt_d  = dcnt_q;
        scnt_d  = scnt_q;
        ovf_d   = ovf_q;
        if (go) begin
            div_d  = divider;
            len_d  = capture_len;
            dcnt_d = '0;
            scnt_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (strobe) begin
                dcnt_d = div_q;
                scnt_d = scnt_q + 16'd1;
            end else if (state_q == RUN && dcnt_q != '0) begin
                dcnt_d = dcnt_q - DIV_W'(1);
            end
            if (strobe && full && !pop) begin
                ovf_d = 1'b1;
            end
        end
    end

`ifdef DATA_CAPTURE_TEST_PATTERN_EN
    always_comb begin
        pat_d = pat_q;
        if (go) begin
            pat_d = '0;
        end else if (strobe) begin
            pat_d = pat_q + DATA_W'(1);
        end
    end
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            div_q      <= '0;
            len_q      <= '0;
            dcnt_q     <= '0;
            scnt_q     <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            div_q      <= div_d;
            len_q      <= len_d;
            dcnt_q     <= dcnt_d;
            scnt_q     <= scnt_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef DATA_CAPTURE_TEST_PATTERN_EN
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_d;
        end
    end
`endif

    always_comb begin
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
        level    = level_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_data_capture_fifo.sv
// Scoreboard bench for data_capture_fifo: directed captures, expected words
// queued by the stimulus and checked by a monitor on every rd_valid.
module tb_data_capture_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  din = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] divider = '0;
    logic [15:0] capture_len = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [4:0]  level;
    logic        running;
    logic        overflow;
`ifdef DATA_CAPTURE_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    data_capture_fifo #(
        .DATA_W(8),
        .DEPTH(16),
        .DIV_W(16)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .input_data_export(din),
        .start(start),
        .stop(stop),
        .divider(divider),
        .capture_len(capture_len),
`ifdef DATA_CAPTURE_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .level(level),
        .running(running),
        .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_n(input int n, input logic [7:0] v);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic reads(input string nm, input int n);
        repeat (n) begin
            @(negedge clk);
            rd_en = 1'b1;
        end
        @(negedge clk);
        rd_en = 1'b0;
        tick(2);
        chk(nm, exp_q.size(), 0);
    endtask

    // monitor: every rd_valid must match the oldest queued expectation
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected: got %0h want none", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        n_err++;
                        $display("FAIL rd_data: got %0h want %0h", rd_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_level", level, 0);
        chk("rst_running", running, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_running", running, 0);
        chk("post_rst_level", level, 0);

        // basic capture
        din = 8'hA5;
        tick(3);
        start = 1'b1; divider = 16'd0; capture_len = 16'd4;
        tick(1);
        start = 1'b0;
        chk("basic_running", running, 1);
        chk("basic_level0", level, 0);
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk("basic_level", level, i);
        end
        chk("basic_done", running, 0);
        chk("basic_ovf", overflow, 0);
        push_n(4, 8'hA5);
        reads("basic_drain", 4);
        chk("basic_empty", level, 0);

        // empty read and stop while idle
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("empty_valid", rd_valid, 0);
        chk("empty_hold", rd_data, 8'hA5);
        chk("empty_level", level, 0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(1);
        chk("idle_stop", running, 0);

        // sample rate: divider 3, stop after 40 clocks
        din = 8'h3C;
        tick(3);
        start = 1'b1; divider = 16'd3; capture_len = 16'd0;
        tick(1);
        start = 1'b0;
        tick(20);
        chk("rate_mid_level", level, 5);
        chk("rate_mid_running", running, 1);
        tick(19);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("rate_stopped", running, 0);
        chk("rate_level", level, 10);
        push_n(10, 8'h3C);
        reads("rate_drain", 10);

        // restart while running keeps buffered words
        din = 8'h77;
        tick(3);
        start = 1'b1; divider = 16'd1; capture_len = 16'd0;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("restart_pre", level, 2);
        start = 1'b1; divider = 16'd0; capture_len = 16'd2;
        tick(1);
        start = 1'b0;
        chk("restart_running", running, 1);
        tick(3);
        chk("restart_level", level, 4);
        chk("restart_done", running, 0);
        push_n(4, 8'h77);
        reads("restart_drain", 4);

        // start and stop together resolve to stop
        start = 1'b1; divider = 16'd5; capture_len = 16'd0;
        tick(1);
        start = 1'b0;
        tick(1);
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("startstop_running", running, 0);
        tick(2);
        chk("startstop_idle", running, 0);
        chk("startstop_level", level, 1);
        push_n(1, 8'h77);
        reads("startstop_drain", 1);

        // overflow with a changing input; first 16 words kept in order
        for (int i = -3; i < 26; i++) begin
            @(negedge clk);
            din = 8'(8'h40 + i);
            start = (i == 0);
            if (i == 0) begin
                divider = 16'd0;
                capture_len = 16'd20;
            end
            if (i == 17) begin
                chk("ovf_full_level", level, 16);
                chk("ovf_not_yet", overflow, 0);
            end
        end
        chk("ovf_level", level, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_done", running, 0);
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(8'(8'h3F + k));
        end
        reads("ovf_drain", 16);

        // full FIFO with a read on every strobe
        din = 8'h11;
        tick(3);
        start = 1'b1; divider = 16'd0; capture_len = 16'd16;
        tick(1);
        start = 1'b0;
        tick(16);
        chk("fullrd_fill", level, 16);
        chk("fullrd_fill_ovf", overflow, 0);
        din = 8'h22;
        tick(3);
        start = 1'b1; divider = 16'd0; capture_len = 16'd3;
        push_n(3, 8'h11);
        tick(1);
        start = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            chk("fullrd_level", level, 16);
        end
        tick(1);
        rd_en = 1'b0;
        chk("fullrd_level_end", level, 16);
        chk("fullrd_ovf", overflow, 0);
        chk("fullrd_done", running, 0);
        tick(2);
        chk("fullrd_popped", exp_q.size(), 0);
        push_n(13, 8'h11);
        push_n(3, 8'h22);
        reads("fullrd_drain", 16);

        // reset in the middle of a capture
        din = 8'h99;
        tick(3);
        start = 1'b1; divider = 16'd0; capture_len = 16'd0;
        tick(1);
        start = 1'b0;
        tick(7);
        chk("midrst_level7", level, 7);
        rd_en = 1'b1;
        push_n(1, 8'h99);
        tick(1);
        rd_en = 1'b0;
        chk("midrst_pre", level, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_level", level, 0);
        chk("midrst_running", running, 0);
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        chk("midrst_after_level", level, 0);
        chk("midrst_after_running", running, 0);
        chk("midrst_queue", exp_q.size(), 0);

`ifdef DATA_CAPTURE_TEST_PATTERN_EN
        test_mode = 1'b1;
        start = 1'b1; divider = 16'd0; capture_len = 16'd5;
        tick(1);
        start = 1'b0;
        tick(5);
        chk("pat_level", level, 5);
        chk("pat_done", running, 0);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(8'(k));
        end
        reads("pat_drain", 5);
        test_mode = 1'b0;
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
